// File: rtl/spi_slave_peripheral_if.sv
// rtl/spi_slave_peripheral_if.sv - SPI pins and host byte interface of spi_slave_peripheral
interface spi_slave_peripheral_if #(
    parameter int DATA_W = 8
);
    logic              spi_clk;
    logic              cs;
    logic              mosi;
    logic              miso;
    logic              polarity;
    logic              phase;
    logic [DATA_W-1:0] tx_data;
    logic              tx_load;
    logic              tx_pending;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              busy;
    logic [3:0]        bit_count;
    logic [1:0]        state;

    modport slave (
        input  spi_clk, cs, mosi, polarity, phase, tx_data, tx_load,
        output miso, tx_pending, rx_data, rx_valid, busy, bit_count, state
    );

    modport master (
        output spi_clk, cs, mosi, polarity, phase, tx_data, tx_load,
        input  miso, tx_pending, rx_data, rx_valid, busy, bit_count, state
    );
endinterface

// File: rtl/spi_slave_peripheral.sv
// rtl/spi_slave_peripheral.sv - oversampled SPI target, all CPOL/CPHA modes, MSB first
module spi_slave_peripheral #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    spi_slave_peripheral_if.slave   bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, WRAP = 2'd2} state_t;

    localparam int         IDXW     = $clog2(DATA_W);
    localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_tx_q, shift_tx_d;
    logic [DATA_W-1:0] shift_rx_q, shift_rx_d;
    logic [DATA_W-1:0] pend_q, pend_d;
    logic              pend_valid_q, pend_valid_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              miso_q, miso_d;
    logic              busy_q, busy_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
    logic cs_fall, cs_rise, reload;
    logic [DATA_W-1:0] next_word;
    logic [IDXW-1:0]   tx_idx;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sclk_rise   = sclk_s & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_s & sclk_prev_q;
    assign lead_edge   = bus.polarity ? sclk_fall : sclk_rise;
    assign trail_edge  = bus.polarity ? sclk_rise : sclk_fall;
    assign sample_edge = bus.phase ? trail_edge : lead_edge;
    assign shift_edge  = bus.phase ? lead_edge : trail_edge;
    assign cs_fall     = ~cs_s & cs_prev_q;
    assign cs_rise     = cs_s & ~cs_prev_q;

    // A same-cycle tx_load bypasses the pending buffer straight into the shifter.
    assign next_word = bus.tx_load ? bus.tx_data : (pend_valid_q ? pend_q : '0);
    assign tx_idx    = IDXW'(LAST_BIT - bit_cnt_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_clk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            shift_tx_q   <= '0;
            shift_rx_q   <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            miso_q       <= 1'b0;
            busy_q       <= 1'b0;
            bit_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            shift_tx_q   <= shift_tx_d;
            shift_rx_q   <= shift_rx_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            miso_q       <= miso_d;
            busy_q       <= busy_d;
            bit_cnt_q    <= bit_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_tx_d   = shift_tx_q;
        shift_rx_d   = shift_rx_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        miso_d       = miso_q;
        busy_d       = busy_q;
        bit_cnt_d    = bit_cnt_q;
        reload       = 1'b0;

        if (bus.tx_load) begin
            pend_d       = bus.tx_data;
            pend_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                miso_d    = 1'b0;
                bit_cnt_d = '0;
                busy_d    = 1'b0;
                if (cs_fall) begin
                    state_d = SHIFT;
                    busy_d  = 1'b1;
                    reload  = 1'b1;
                end
            end
            SHIFT: begin
                if (sample_edge) begin
                    shift_rx_d = {shift_rx_q[DATA_W-2:0], mosi_s};
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_data_d  = shift_rx_d;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        state_d    = WRAP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                // With CPHA=0 the MSB is already out; a trailing edge at count 0 is the dead one after the last bit.
                end else if (shift_edge && (bus.phase || bit_cnt_q != '0)) begin
                    miso_d = shift_tx_q[tx_idx];
                end
            end
            WRAP: begin
                state_d = SHIFT;
                reload  = ~cs_rise;
            end
            default: state_d = IDLE;
        endcase

        if (reload) begin
            shift_tx_d   = next_word;
            pend_valid_d = 1'b0;
            if (!bus.phase) begin
                miso_d = next_word[DATA_W-1];
            end
        end

        if (cs_rise && state_q != IDLE) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            miso_d    = 1'b0;
            bit_cnt_d = '0;
        end
    end

    assign bus.miso       = miso_q;
    assign bus.tx_pending = pend_valid_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.busy       = busy_q;
    assign bus.bit_count  = bit_cnt_q;
    assign bus.state      = state_q;
endmodule

// File: doc/spi_slave_peripheral.md
Name: spi_slave_peripheral

Overview:
- SPI target stage that sits directly downstream of spi_master_slave on the same board-level bus.
- Consumes spi_clk, cs and mosi, and drives miso back to the master.
- Oversamples all SPI pins in the system clk domain, supports the four polarity/phase modes, and shifts MSB first.
- Presents each received byte as a one-cycle valid pulse, with a double-buffered transmit byte for back-to-back transfers.

Parameters:
- DATA_W, 8: bits per SPI word.
- SYNC_STAGES, 2: depth of the input synchronizer for spi_clk, cs and mosi; minimum 2.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- spi_clk  input  1  serial clock from the master (asynchronous to clk).
- cs  input  1  chip select, active low.
- mosi  input  1  serial data from the master.
- miso  output  1  serial data to the master.
- polarity  input  1  CPOL; the spi_clk idle level.
- phase  input  1  CPHA. 0 = sample on the leading edge; 1 = sample on the trailing edge.
- tx_data  input  DATA_W  next byte to transmit.
- tx_load  input  1  writes tx_data into the pending buffer.
- tx_pending  output  1  pending buffer is full and not yet consumed.
- rx_data  output  DATA_W  last complete received byte.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- busy  output  1  cs is asserted (after synchronization).
- bit_count  output  4  bits sampled in the current word, 0..DATA_W-1.
- state  output  2  FSM state: 0 IDLE, 1 SHIFT, 2 WRAP.

Behaviour:
- Reset: every output and internal register is synchronous to clk and cleared when reset=1.
  - miso=0, rx_data=0, rx_valid=0, tx_pending=0, busy=0, bit_count=0, state=IDLE.
  - shift_tx=0, shift_rx=0, pending buffer=0.
  - Reset has priority over all other events, including mid-transfer; the partial word is discarded.
- Synchronization and edge detection:
  - spi_clk, cs and mosi each pass through SYNC_STAGES flops.
  - Edges are detected by comparing the synchronized value against a one-cycle delayed copy.
  - Leading edge = synchronized spi_clk leaves the polarity level; trailing edge = it returns to it.
  - Sample edge = leading if phase=0, trailing if phase=1. Shift edge = the other edge.
- Timing requirement: the spi_clk high and low phases must each be at least SYNC_STAGES+1 clk cycles. Faster clocks are outside the specification.
- Pending buffer:
  - tx_load=1 writes tx_data into the pending buffer and sets tx_pending, in any state.
  - A load while tx_pending=1 overwrites the buffer; the last write wins.
- IDLE:
  - miso=0, bit_count=0.
  - On the synchronized cs falling edge, go to SHIFT and set busy=1.
  - shift_tx loads from the pending buffer if tx_pending=1 (clear tx_pending); otherwise it loads 0x00.
  - If phase=0, miso = the MSB of the newly loaded value in the same cycle as the state change.
- SHIFT:
  - Sample edge: shift_rx <= {shift_rx[DATA_W-2:0], mosi_sync}, and bit_count increments.
  - Shift edge, phase=0: miso takes the next bit of shift_tx.
  - Shift edge, phase=1: the first leading edge of a word drives the MSB; each later leading edge drives the next bit.
  - A shift edge after the last bit of a word has no effect.
  - On the DATA_W-th sample: next cycle rx_data = the completed word and rx_valid=1 for one cycle; bit_count wraps to 0; go to WRAP.
- WRAP (1 cycle):
  - shift_tx reloads from the pending buffer if tx_pending=1 (clear tx_pending); otherwise it reloads 0x00.
  - If phase=0, miso = the new MSB.
  - Return to SHIFT, so multiple words can be transferred under one cs assertion.
- cs rising edge in any non-IDLE state:
  - Go to IDLE; busy=0, miso=0, bit_count=0.
  - A partial word produces no rx_valid and rx_data keeps its old value.
  - A load that was taken but only partly shifted out is lost; tx_pending is unaffected.
- Simultaneous events:
  - cs rising edge in the same cycle as the final sample edge: the word completes and rx_valid fires, then the block goes to IDLE.
  - tx_load in the same cycle as the WRAP or IDLE→SHIFT load: the new tx_data is loaded directly and tx_pending stays 0.
- Polarity or phase changes are only permitted while busy=0; behaviour while busy=1 is undefined.

Test Plan:
- Mode 0 (polarity=0, phase=0), tx_load 0xA5, master sends 0xAF:
  - miso bits over the word = 1,0,1,0,0,1,0,1.
  - rx_data=0xAF with a single rx_valid pulse; tx_pending cleared when cs falls.
- Modes 1, 2 and 3, each with tx 0x3C and mosi 0xCA:
  - rx_data=0xCA in every mode, and the miso pattern matches 0x3C MSB first.
  - Every miso change must occur on the shift edge, never within SYNC_STAGES+1 clk of a sample edge.
- Back-to-back words under one cs, mode 0:
  - tx_load 0x11, then tx_load 0x22 during the first word.
  - Two rx_valid pulses, miso sends 0x11 then 0x22, bit_count reads 0..7 twice.
  - A third word with no load transmits 0x00.
- Abort: cs released after 5 sample edges:
  - No rx_valid, rx_data keeps its previous value, state=IDLE, bit_count=0, miso=0.
  - The next full transfer receives correctly.
- Reset mid-word: reset=1 for 1 cycle after 3 bits:
  - All outputs return to their reset values on the next clk, including tx_pending=0.
  - After reset=0 and a fresh cs fall, a full 0x5A word is received correctly.
- Simultaneous events:
  - tx_load 0x77 in the exact WRAP cycle: the next word transmits 0x77 and tx_pending stays 0.
  - cs rising edge on the 8th sample edge: rx_valid fires, then state=IDLE.
